fib_stream_checker: RTL

// - Receiving end of the Fibonacci test stream: consumes the 16-bit sequence a Fibonacci

---
 rtl/fib_stream_checker_pkg.sv | 13 +
 rtl/fib_stream_checker_adder.sv | 20 ++
 rtl/fib_stream_checker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fib_stream_checker_pkg.sv
// Shared constants for the Fibonacci stream checker: FSM state codes and seed value.
package fib_stream_checker_pkg;

    // FSM state encodings (2 bits, legacy-compatible constants)
    localparam logic [1:0] ST_SEED0 = 2'd0;
    localparam logic [1:0] ST_SEED1 = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    // Value both seed terms must carry when seed checking is enabled
    localparam logic [15:0] SEED_VAL = 16'd1;

endpackage

// File: rtl/fib_stream_checker_adder.sv
// Adder_16: plain 16-bit ripple adder with carry-in and carry-out.
module Adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] full_s;

    // Widen both operands so the carry-out lands in bit 16
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    end

    assign sum  = full_s[15:0];
    assign cout = full_s[16];

endmodule

// File: rtl/fib_stream_checker.sv
// fib_stream_checker: consumes a 16-bit Fibonacci stream (1,1,2,3,... mod 2^16) and
// checks each term against prev+cur. Reports lock, first-error capture, a saturating
// accepted-term count and a sticky 16-bit wrap indication. All outputs are registered.
module fib_stream_checker
    import fib_stream_checker_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit CHECK_SEED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             locked,
    output logic             error,
    output logic [15:0]      err_expected,
    output logic [15:0]      err_got,
    output logic [CNT_W-1:0] err_index,
    output logic [CNT_W-1:0] term_count,
    output logic             wrap_seen
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Registered state
    logic [1:0]       state_r;
    logic [15:0]      prev_r;
    logic [15:0]      cur_r;
    logic             locked_r;
    logic             error_r;
    logic [15:0]      err_expected_r;
    logic [15:0]      err_got_r;
    logic [CNT_W-1:0] err_index_r;
    logic [CNT_W-1:0] term_count_r;
    logic             wrap_seen_r;

    // Next-state values
    logic [1:0]       state_nxt_s;
    logic [15:0]      prev_nxt_s;
    logic [15:0]      cur_nxt_s;
    logic             locked_nxt_s;
    logic             error_nxt_s;
    logic [15:0]      err_expected_nxt_s;
    logic [15:0]      err_got_nxt_s;
    logic [CNT_W-1:0] err_index_nxt_s;
    logic [CNT_W-1:0] term_count_nxt_s;
    logic             wrap_seen_nxt_s;

    // Datapath helpers
    logic [15:0]      exp_sum_s;
    logic             exp_carry_s;
    logic [CNT_W-1:0] count_inc_s;
    logic             seed_bad_s;

    // The only adder in the checker: expected next term is prev+cur
    Adder_16 u_adder (
        .a    (prev_r),
        .b    (cur_r),
        .cin  (1'b0),
        .sum  (exp_sum_s),
        .cout (exp_carry_s)
    );

    // Saturating increment of the accepted-term counter and seed validity test
    always_comb begin
        if (term_count_r == CNT_MAX) begin
            count_inc_s = term_count_r;
        end else begin
            count_inc_s = term_count_r + CNT_ONE;
        end
        seed_bad_s = CHECK_SEED && (in_data != SEED_VAL);
    end

    // FSM and status next-state: advances only on a valid term; ERROR is terminal
    always_comb begin
        state_nxt_s        = state_r;
        prev_nxt_s         = prev_r;
        cur_nxt_s          = cur_r;
        locked_nxt_s       = locked_r;
        error_nxt_s        = error_r;
        err_expected_nxt_s = err_expected_r;
        err_got_nxt_s      = err_got_r;
        err_index_nxt_s    = err_index_r;
        term_count_nxt_s   = term_count_r;
        wrap_seen_nxt_s    = wrap_seen_r;

        if (in_valid) begin
            case (state_r)
                ST_SEED0: begin
                    prev_nxt_s = in_data;
                    if (seed_bad_s) begin
                        state_nxt_s        = ST_ERROR;
                        error_nxt_s        = 1'b1;
                        err_expected_nxt_s = SEED_VAL;
                        err_got_nxt_s      = in_data;
                        err_index_nxt_s    = CNT_ZERO;
                    end else begin
                        state_nxt_s      = ST_SEED1;
                        term_count_nxt_s = count_inc_s;
                    end
                end
                ST_SEED1: begin
                    cur_nxt_s = in_data;
                    if (seed_bad_s) begin
                        state_nxt_s        = ST_ERROR;
                        error_nxt_s        = 1'b1;
                        err_expected_nxt_s = SEED_VAL;
                        err_got_nxt_s      = in_data;
                        err_index_nxt_s    = CNT_ONE;
                    end else begin
                        state_nxt_s      = ST_TRACK;
                        term_count_nxt_s = count_inc_s;
                        locked_nxt_s     = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (in_data == exp_sum_s) begin
                        prev_nxt_s       = cur_r;
                        cur_nxt_s        = in_data;
                        term_count_nxt_s = count_inc_s;
                        if (exp_carry_s) begin
                            wrap_seen_nxt_s = 1'b1;
                        end else begin
                            wrap_seen_nxt_s = wrap_seen_r;
                        end
                    end else begin
                        state_nxt_s        = ST_ERROR;
                        error_nxt_s        = 1'b1;
                        locked_nxt_s       = 1'b0;
                        err_expected_nxt_s = exp_sum_s;
                        err_got_nxt_s      = in_data;
                        err_index_nxt_s    = term_count_r;
                    end
                end
                ST_ERROR: begin
                    state_nxt_s = ST_ERROR;
                end
                default: begin
                    state_nxt_s = ST_ERROR;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State registers: async reset, clear restarts from SEED0 with all status cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_SEED0;
            prev_r         <= 16'd0;
            cur_r          <= 16'd0;
            locked_r       <= 1'b0;
            error_r        <= 1'b0;
            err_expected_r <= 16'd0;
            err_got_r      <= 16'd0;
            err_index_r    <= CNT_ZERO;
            term_count_r   <= CNT_ZERO;
            wrap_seen_r    <= 1'b0;
        end else if (clear) begin
            state_r        <= ST_SEED0;
            prev_r         <= 16'd0;
            cur_r          <= 16'd0;
            locked_r       <= 1'b0;
            error_r        <= 1'b0;
            err_expected_r <= 16'd0;
            err_got_r      <= 16'd0;
            err_index_r    <= CNT_ZERO;
            term_count_r   <= CNT_ZERO;
            wrap_seen_r    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            prev_r         <= prev_nxt_s;
            cur_r          <= cur_nxt_s;
            locked_r       <= locked_nxt_s;
            error_r        <= error_nxt_s;
            err_expected_r <= err_expected_nxt_s;
            err_got_r      <= err_got_nxt_s;
            err_index_r    <= err_index_nxt_s;
            term_count_r   <= term_count_nxt_s;
            wrap_seen_r    <= wrap_seen_nxt_s;
        end
    end

    assign locked       = locked_r;
    assign error        = error_r;
    assign err_expected = err_expected_r;
    assign err_got      = err_got_r;
    assign err_index    = err_index_r;
    assign term_count   = term_count_r;
    assign wrap_seen    = wrap_seen_r;

endmodule
